// File: rtl/nv_nvdla_cmac_core_cfg_pipe.sv
// CMAC core configuration unit.
// Detects layer start, shadows precision and conv mode for the layer, drives
// a delayed per-channel winograd SLCG enable bus and tracks layer progress.
module nv_nvdla_cmac_core_cfg_pipe #(
   parameter int unsigned SLCG_NUM = 9,
   parameter int unsigned SLCG_DLY = 2,
   parameter int unsigned LCNT_W   = 8
) (
   input  logic                nvdla_core_clk,
   input  logic                nvdla_core_rstn,
   input  logic                dp2reg_done,
   input  logic                reg2dp_op_en,
   input  logic                reg2dp_conv_mode,
   input  logic [1:0]          reg2dp_proc_precision,
   input  logic [SLCG_NUM-1:0] reg2dp_slcg_wg_mask,
   output logic                cfg_reg_en,
   output logic                cfg_is_int8,
   output logic                cfg_is_int16,
   output logic                cfg_is_fp16,
   output logic                cfg_is_wg,
   output logic                cfg_ready,
   output logic                cfg_prec_err,
   output logic [SLCG_NUM-1:0] slcg_wg_en,
   output logic [LCNT_W-1:0]   layer_cnt
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(SLCG_DLY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CFG  = 2'd1,
      ST_BUSY = 2'd2
   } cfg_state_t;

   cfg_state_t          state;
   cfg_state_t          state_nxt;
   logic                op_en_d1;
   logic                op_done_d1;
   logic [CNT_W-1:0]    cfg_cnt;
   logic [SLCG_NUM-1:0] mask_latched;

   // Edge history of op_en/done and the registered layer-start pulse
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         op_en_d1   <= 1'b0;
         op_done_d1 <= 1'b0;
         cfg_reg_en <= 1'b0;
      end else begin
         op_en_d1   <= reg2dp_op_en;
         op_done_d1 <= dp2reg_done;
         cfg_reg_en <= reg2dp_op_en & (~op_en_d1 | op_done_d1);
      end
   end

   // Shadow config: loaded only in the cycle following the start pulse
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cfg_is_int8  <= 1'b0;
         cfg_is_int16 <= 1'b1;
         cfg_is_fp16  <= 1'b0;
         cfg_is_wg    <= 1'b0;
         cfg_prec_err <= 1'b0;
         mask_latched <= '0;
      end else begin
         cfg_prec_err <= 1'b0;
         if (cfg_reg_en) begin
            cfg_is_wg    <= reg2dp_conv_mode;
            mask_latched <= reg2dp_slcg_wg_mask;
            case (reg2dp_proc_precision)
               2'd0: begin
                  cfg_is_int8  <= 1'b1;
                  cfg_is_int16 <= 1'b0;
                  cfg_is_fp16  <= 1'b0;
               end
               2'd1: begin
                  cfg_is_int8  <= 1'b0;
                  cfg_is_int16 <= 1'b1;
                  cfg_is_fp16  <= 1'b0;
               end
               2'd2: begin
                  cfg_is_int8  <= 1'b0;
                  cfg_is_int16 <= 1'b0;
                  cfg_is_fp16  <= 1'b1;
               end
               default: begin
                  // reserved precision: flags keep their prior values
                  cfg_prec_err <= 1'b1;
               end
            endcase
         end
      end
   end

   // SLCG pipeline: each stage carries its own enable bit and data word,
   // so the chain length follows SLCG_DLY without variable indexing.
   for (genvar k = 0; k < SLCG_DLY; k++) begin : g_stage
      logic                en;
      logic                en_d;
      logic [SLCG_NUM-1:0] q;
      logic [SLCG_NUM-1:0] d;

      if (k == 0) begin : g_head
         assign en_d = cfg_reg_en;
         assign d    = {SLCG_NUM{cfg_is_wg}} & mask_latched;
      end else begin : g_body
         assign en_d = g_stage[k-1].en;
         assign d    = g_stage[k-1].q;
      end

      // Stage register: enable follows the start pulse, data loads on enable
      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
         if (!nvdla_core_rstn) begin
            en <= 1'b0;
            q  <= '0;
         end else begin
            en <= en_d;
            if (en) begin
               q <= d;
            end
         end
      end
   end

   assign slcg_wg_en = g_stage[SLCG_DLY-1].q;

   // FSM state register
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: any start pulse (re)enters CFG; done only ends BUSY
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cfg_reg_en) begin
               state_nxt = ST_CFG;
            end
         end
         ST_CFG: begin
            if (cfg_reg_en) begin
               state_nxt = ST_CFG;
            end else if (cfg_cnt == CFG_LAST) begin
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cfg_reg_en) begin
               state_nxt = ST_CFG;
            end else if (dp2reg_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      cfg_ready = (state == ST_BUSY);
   end

   // CFG dwell counter, cleared by every start pulse so a restart runs fully
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cfg_cnt <= '0;
      end else if (cfg_reg_en) begin
         cfg_cnt <= '0;
      end else if (state == ST_CFG) begin
         cfg_cnt <= cfg_cnt + CNT_W'(1);
      end
   end

   // Completed-layer counter: done counts only in BUSY, even alongside a start
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         layer_cnt <= '0;
      end else if ((state == ST_BUSY) && dp2reg_done) begin
         layer_cnt <= layer_cnt + LCNT_W'(1);
      end
   end

endmodule
